// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes and FSM states.
// The control decoder imports the same package to generate op.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2
  } md_state_e;

  // MULT/MULTU/DIV/DIVU all have op[2]==0; op[1] selects divide, op[0] selects unsigned.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one iteration per cycle, sign fix-up in a final cycle, plus MTHI/MTLO writes.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              mf_req,
  input  logic              flush,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int ACC_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic is_signed);
    if (is_signed && (v < 0)) return -v;
    return v;
  endfunction

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  dvsr_q, dvsr_d;
  logic [DATA_W-1:0]  orig_q, orig_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic               done_q, done_d;

  logic               op_signed;
  logic [DATA_W-1:0]  rs_abs, rt_abs;
  logic [DATA_W:0]    mul_sum;
  logic [DATA_W:0]    rem_sh;
  logic [DATA_W-1:0]  rem_diff;
  logic               rem_ge;
  logic [ACC_W-1:0]   mul_step, div_step, prod_fix;
  logic [DATA_W-1:0]  quot, rem;

  assign op_signed = ~op[0];
  assign rs_abs    = mag(rs_val, op_signed);
  assign rt_abs    = mag(rt_val, op_signed);

  // Multiply: low half holds the remaining multiplier bits, product grows in from the top.
  assign mul_sum  = {1'b0, acc_q[ACC_W-1:DATA_W]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
  assign mul_step = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: {remainder, quotient} shift left; diff only needs DATA_W bits when it is kept.
  assign rem_sh   = {acc_q[ACC_W-1:DATA_W], acc_q[DATA_W-1]};
  assign rem_diff = rem_sh[DATA_W-1:0] - dvsr_q;
  assign rem_ge   = rem_sh >= {1'b0, dvsr_q};
  assign div_step = rem_ge ? {rem_diff, acc_q[DATA_W-2:0], 1'b1}
                           : {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot     = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem      = neg_rem_q ? -acc_q[ACC_W-1:DATA_W] : acc_q[ACC_W-1:DATA_W];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    dvsr_d    = dvsr_q;
    orig_d    = orig_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (is_arith(op)) begin
            state_d   = S_RUN;
            count_d   = '0;
            is_div_d  = op[1];
            neg_res_d = op_signed & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
            neg_rem_d = op_signed & rs_val[DATA_W-1];
            orig_d    = rs_val;
            if (op[1]) begin
              acc_d  = {{DATA_W{1'b0}}, rs_abs};
              dvsr_d = rt_abs;
            end else begin
              acc_d  = {{DATA_W{1'b0}}, rt_abs};
              dvsr_d = rs_abs;
            end
          end else if (op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (op == MD_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = is_div_q ? div_step : mul_step;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_ITER) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (dvsr_q == '0) begin
            hi_d = orig_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      dvsr_q    <= '0;
      orig_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      dvsr_q    <= dvsr_d;
      orig_q    <= orig_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      done_q    <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (mf_req | start);
  assign done  = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed HI/LO results, latency, stall, flush, reset.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mf_req (mf_req),
    .flush  (flush),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit so checks and drives sit away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle (edge E0); returns just after E0.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    step();
    start  = 1'b0;
    op     = 3'b111;
  endtask

  // Full MULT*/DIV* transaction with latency, busy and done checks.
  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(o, a, b);
    check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    repeat (32) step();
    check({tag, "_busy_e32"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_e32"}, {31'd0, done}, 32'd0);
    step();
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    step();
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'b111;
    rs_val = '0;
    rt_val = '0;
    mf_req = 1'b0;
    flush  = 1'b0;
    step();
    step();
    reset = 1'b1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // Arithmetic results
    run_md("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_md("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_7_m2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_md("div_by0", 3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_md("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // MFHI/MFLO held from the cycle after E0: stalled through FIXUP, released after E33
    issue(3'b000, 32'd7, 32'hFFFFFFFA);
    mf_req = 1'b1;
    for (int i = 0; i < 33; i++) begin
      check("mf_stall", {31'd0, stall}, 32'd1);
      step();
    end
    check("mf_release", {31'd0, stall}, 32'd0);
    check("mf_hi", hi, 32'hFFFFFFFF);
    check("mf_lo", lo, 32'hFFFFFFD6);
    mf_req = 1'b0;
    step();

    // start while busy is stalled and ignored; op still completes normally
    issue(3'b011, 32'd100, 32'd7);
    repeat (4) step();
    start  = 1'b1;
    op     = 3'b100;
    rs_val = 32'hDEADBEEF;
    #1;
    check("busy_start_stall", {31'd0, stall}, 32'd1);
    step();
    start = 1'b0;
    op    = 3'b111;
    check("busy_start_hi", hi, 32'hFFFFFFFF);
    repeat (27) step();
    check("busy_start_busy", {31'd0, busy}, 32'd1);
    step();
    check("busy_start_res_hi", hi, 32'd2);
    check("busy_start_res_lo", lo, 32'd14);
    step();

    // MTHI/MTLO in idle
    issue(3'b100, 32'h12345678, 32'h0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'd14);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    issue(3'b101, 32'h9ABCDEF0, 32'h0);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // flush in IDLE blocks start
    flush = 1'b1;
    issue(3'b100, 32'h55555555, 32'h0);
    check("idle_flush_hi", hi, 32'h12345678);
    issue(3'b000, 32'd3, 32'd3);
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    flush = 1'b0;

    // flush at E10 aborts, hi/lo untouched, no done
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, 32'h12345678);
    check("flush_lo", lo, 32'h9ABCDEF0);
    repeat (30) step();
    check("flush_no_done", {31'd0, done}, 32'd0);
    check("flush_hi_late", hi, 32'h12345678);
    check("flush_lo_late", lo, 32'h9ABCDEF0);

    // reset at E10 mid-DIVU clears everything
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);

    // unit accepts a fresh op after mid-op reset
    run_md("post_rst_mult", 3'b000, 32'd6, 32'd7, 32'h0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
